// File: rtl/reg_write_arbiter_if.sv
// Register-file write port bundle: two requester handshakes plus the merged write port.
// The arbiter sits on the slave side; requesters and the register file sit on the master side.
interface reg_write_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic [3:0]        req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;

    logic              req1_valid;
    logic [3:0]        req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    logic              WE3;
    logic [3:0]        A3;
    logic [DATA_W-1:0] WD3;
    logic [14:0]       pending;
    logic              drop_pc;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  WE3, A3, WD3, pending, drop_pc
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output WE3, A3, WD3, pending, drop_pc
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Two-requester register-file write arbiter: one buffer slot per requester, round-robin
// between full slots, writes to register 15 (PC) are discarded with a drop_pc pulse.
module reg_write_arbiter #(
    parameter int DATA_W  = 32,
    parameter int RR_INIT = 0
) (
    input  logic             CLK,
    input  logic             RESETn,
    reg_write_arbiter_if.slave bus
);
    localparam logic [3:0] PC_ADDR = 4'hF;

    typedef enum logic {
        PRI_REQ0 = 1'b0,
        PRI_REQ1 = 1'b1
    } pri_t;

    localparam pri_t PRI_INIT = (RR_INIT == 0) ? PRI_REQ0 : PRI_REQ1;

    pri_t pri_reg;
    pri_t pri_next;

    logic [1:0]              req_valid;
    logic [1:0][3:0]         req_addr;
    logic [1:0][DATA_W-1:0]  req_data;
    logic [1:0]              req_ready;
    logic [1:0]              accept;

    logic [1:0]              slot_full_reg;
    logic [1:0]              slot_full_next;
    logic [1:0][3:0]         slot_addr_reg;
    logic [1:0][3:0]         slot_addr_next;
    logic [1:0][DATA_W-1:0]  slot_data_reg;
    logic [1:0][DATA_W-1:0]  slot_data_next;

    logic [1:0]              grant;
    logic                    any_grant;
    logic [3:0]              gnt_addr;
    logic [DATA_W-1:0]       gnt_data;
    logic [14:0]             pending_vec;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign req_addr  = {bus.req1_addr,  bus.req0_addr};
    assign req_data  = {bus.req1_data,  bus.req0_data};

    // Grant looks only at slot state, so ready (which depends on grant) has no path from valid.
    always_comb begin
        grant = 2'b00;
        case (slot_full_reg)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (pri_reg == PRI_REQ0) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign any_grant = |grant;

    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        if (grant[0]) begin
            gnt_addr = slot_addr_reg[0];
            gnt_data = slot_data_reg[0];
        end else if (grant[1]) begin
            gnt_addr = slot_addr_reg[1];
            gnt_data = slot_data_reg[1];
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_handshake
            // A slot being drained this cycle can take a new entry at the same edge.
            assign req_ready[gi] = !slot_full_reg[gi] || grant[gi];
            assign accept[gi]    = req_valid[gi] && req_ready[gi];
        end
    endgenerate

    always_comb begin
        slot_full_next = slot_full_reg;
        slot_addr_next = slot_addr_reg;
        slot_data_next = slot_data_reg;
        for (int i = 0; i < 2; i++) begin
            if (accept[i]) begin
                slot_full_next[i] = 1'b1;
                slot_addr_next[i] = req_addr[i];
                slot_data_next[i] = req_data[i];
            end else if (grant[i]) begin
                slot_full_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            slot_full_reg <= '0;
            slot_addr_reg <= '0;
            slot_data_reg <= '0;
        end else begin
            slot_full_reg <= slot_full_next;
            slot_addr_reg <= slot_addr_next;
            slot_data_reg <= slot_data_next;
        end
    end

    always_comb begin
        pri_next = pri_reg;
        if (grant[0]) begin
            pri_next = PRI_REQ1;
        end else if (grant[1]) begin
            pri_next = PRI_REQ0;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            pri_reg <= PRI_INIT;
        end else begin
            pri_reg <= pri_next;
        end
    end

    // Register 15 never appears here because the index only runs to 14.
    generate
        for (genvar gi = 0; gi < 15; gi++) begin : g_pending
            assign pending_vec[gi] = (slot_full_reg[0] && (slot_addr_reg[0] == 4'(gi))) ||
                                     (slot_full_reg[1] && (slot_addr_reg[1] == 4'(gi)));
        end
    endgenerate

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];
    assign bus.WE3        = any_grant && (gnt_addr != PC_ADDR);
    assign bus.drop_pc    = any_grant && (gnt_addr == PC_ADDR);
    assign bus.A3         = gnt_addr;
    assign bus.WD3        = gnt_data;
    assign bus.pending    = pending_vec;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed and random stimulus for reg_write_arbiter, checked against a queue-based
// model of the two requester buffers and of the register file they write into.
module tb_reg_write_arbiter;
    localparam int DW = 32;

    logic CLK    = 1'b0;
    logic RESETn = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    reg_write_arbiter_if #(.DATA_W(DW)) bus ();

    reg_write_arbiter #(.DATA_W(DW), .RR_INIT(0)) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]    addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           q0[$];
    wr_t           q1[$];
    int            pri;
    logic [DW-1:0] rf_model [16];
    logic [DW-1:0] rf_dut   [16];

    logic          last_we, last_drop, last_r1;
    logic [3:0]    last_a3;
    logic [DW-1:0] last_wd;
    logic [14:0]   last_pend;
    logic [3:0]    prev_a3;
    int            we_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [3:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [3:0] a1, input logic [DW-1:0] d1);
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        bus.req1_data  = d1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".we"},   64'(bus.WE3),        64'(0));
        chk({tag, ".a3"},   64'(bus.A3),         64'(0));
        chk({tag, ".wd3"},  64'(bus.WD3),        64'(0));
        chk({tag, ".pend"}, 64'(bus.pending),    64'(0));
        chk({tag, ".drop"}, 64'(bus.drop_pc),    64'(0));
        chk({tag, ".rdy0"}, 64'(bus.req0_ready), 64'(1));
        chk({tag, ".rdy1"}, 64'(bus.req1_ready), 64'(1));
    endtask

    // One clock cycle: compare mid-cycle outputs with the model, then advance the model at the edge.
    task automatic step(input string tag);
        int          g;
        wr_t         gw;
        wr_t         nw;
        logic [14:0] ep;
        logic        r0e, r1e;
        @(negedge CLK);
        g = -1;
        if (q0.size() > 0 && q1.size() > 0) g = pri;
        else if (q0.size() > 0)             g = 0;
        else if (q1.size() > 0)             g = 1;
        gw.addr = '0;
        gw.data = '0;
        if (g == 0) gw = q0[0];
        if (g == 1) gw = q1[0];
        ep = '0;
        foreach (q0[i]) if (q0[i].addr != 4'hF) ep[q0[i].addr] = 1'b1;
        foreach (q1[i]) if (q1[i].addr != 4'hF) ep[q1[i].addr] = 1'b1;
        r0e = (q0.size() == 0) || (g == 0);
        r1e = (q1.size() == 0) || (g == 1);

        last_we   = bus.WE3;
        last_drop = bus.drop_pc;
        last_r1   = bus.req1_ready;
        last_a3   = bus.A3;
        last_wd   = bus.WD3;
        last_pend = bus.pending;

        chk({tag, ".we"},   64'(bus.WE3),        64'(g >= 0 && gw.addr != 4'hF));
        chk({tag, ".drop"}, 64'(bus.drop_pc),    64'(g >= 0 && gw.addr == 4'hF));
        chk({tag, ".a3"},   64'(bus.A3),         64'(gw.addr));
        chk({tag, ".wd3"},  64'(bus.WD3),        64'(gw.data));
        chk({tag, ".pend"}, 64'(bus.pending),    64'(ep));
        chk({tag, ".rdy0"}, 64'(bus.req0_ready), 64'(r0e));
        chk({tag, ".rdy1"}, 64'(bus.req1_ready), 64'(r1e));
        if (bus.WE3 === 1'b1) rf_dut[bus.A3] = bus.WD3;

        @(posedge CLK);
        if (g >= 0) begin
            if (gw.addr != 4'hF) rf_model[gw.addr] = gw.data;
            if (g == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            pri = 1 - g;
        end
        if (bus.req0_valid && r0e) begin
            nw.addr = bus.req0_addr;
            nw.data = bus.req0_data;
            q0.push_back(nw);
        end
        if (bus.req1_valid && r1e) begin
            nw.addr = bus.req1_addr;
            nw.data = bus.req1_data;
            q1.push_back(nw);
        end
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        pri = 0;
        for (int i = 0; i < 16; i++) begin
            rf_model[i] = '0;
            rf_dut[i]   = '0;
        end

        #3;
        chk_reset_outputs("rst");
        #4 RESETn = 1'b1;

        // Contention from reset, priority starts at requester 0.
        drive(1, 4'd1, 32'h11, 1, 4'd2, 32'h22);
        step("con_acc");
        drive(0, 0, 0, 0, 0, 0);
        step("con1");
        chk("con1.a3", 64'(last_a3), 64'(1));
        chk("con1.rdy1", 64'(last_r1), 64'(0));
        step("con2");
        chk("con2.a3", 64'(last_a3), 64'(2));
        step("con3");

        // Single write.
        drive(1, 4'd3, 32'h0000_00AA, 0, 0, 0);
        step("sgl_acc");
        drive(0, 0, 0, 0, 0, 0);
        step("sgl1");
        chk("sgl1.we", 64'(last_we), 64'(1));
        chk("sgl1.a3", 64'(last_a3), 64'(3));
        chk("sgl1.wd3", 64'(last_wd), 64'(32'hAA));
        chk("sgl1.pend3", 64'(last_pend[3]), 64'(1));
        step("sgl2");
        chk("sgl2.pend", 64'(last_pend), 64'(0));

        // Sustained contention alternates between requesters.
        prev_a3 = '0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 4'd6, $urandom, 1, 4'd7, $urandom);
            step("alt");
            if (i >= 2) chk("alt.toggle", 64'(last_a3 != prev_a3), 64'(1));
            prev_a3 = last_a3;
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) step("alt_idle");

        // Uncontested back-to-back writes.
        we_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'd9, $urandom, 0, 0, 0);
            step("unc");
            if (last_we) we_cnt++;
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step("unc_idle");
            if (last_we) we_cnt++;
        end
        chk("unc.we_count", 64'(we_cnt), 64'(4));

        // Write to PC is dropped.
        drive(0, 0, 0, 1, 4'hF, 32'hDEAD_BEEF);
        step("pc_acc");
        drive(0, 0, 0, 0, 0, 0);
        step("pc1");
        chk("pc1.drop", 64'(last_drop), 64'(1));
        chk("pc1.we", 64'(last_we), 64'(0));
        chk("pc1.pend", 64'(last_pend), 64'(0));
        step("pc2");
        chk("pc2.drop", 64'(last_drop), 64'(0));

        // Both requesters target the same register.
        drive(1, 4'd5, 32'h1, 1, 4'd5, 32'h2);
        step("same_acc");
        drive(0, 0, 0, 0, 0, 0);
        step("same1");
        chk("same1.a3", 64'(last_a3), 64'(5));
        chk("same1.pend5", 64'(last_pend[5]), 64'(1));
        step("same2");
        chk("same2.we", 64'(last_we), 64'(1));
        chk("same2.a3", 64'(last_a3), 64'(5));
        chk("same2.pend5", 64'(last_pend[5]), 64'(1));
        step("same3");
        chk("same3.pend5", 64'(last_pend[5]), 64'(0));
        chk("same.rf5", 64'(rf_dut[5]), 64'(rf_model[5]));

        // Reset pulse while both slots hold writes.
        drive(1, 4'd10, $urandom, 1, 4'd11, $urandom);
        step("rm_acc");
        drive(0, 0, 0, 0, 0, 0);
        #1 RESETn = 1'b0;
        #1;
        chk_reset_outputs("rm_rst");
        q0.delete();
        q1.delete();
        pri = 0;
        #1 RESETn = 1'b1;
        we_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step("rm_idle");
            if (last_we) we_cnt++;
        end
        chk("rm.we_count", 64'(we_cnt), 64'(0));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom);
            step("rnd");
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) step("rnd_idle");

        for (int i = 0; i < 16; i++) begin
            chk($sformatf("rf%0d", i), 64'(rf_dut[i]), 64'(rf_model[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
